// File: rtl/aes_pkg.sv
// Shared types and constants for the AES clearing-PRNG arbiter.
package aes_pkg;

    localparam int unsigned PrngClrReseedPeriodDefault = 1024;

    // One-hot state encoding keeps the decode of each output a single flop bit.
    typedef enum logic [2:0] {
        CLR_IDLE   = 3'b001,
        CLR_DATA   = 3'b010,
        CLR_RESEED = 3'b100
    } aes_prng_clr_arb_e;

endpackage

// File: rtl/aes_prng_clr_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module aes_prng_clr_rr_arb
    import aes_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              valid_o,
    output logic [IdxW-1:0]   idx_o
);

    logic            w_found;
    logic [IdxW-1:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        idx_o   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            w_cand = IdxW'((32'(ptr_i) + k) % NumReq);
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                idx_o   = w_cand;
            end
        end
        valid_o = w_found;
    end

endmodule

// File: rtl/aes_prng_clearing_arb.sv
// Round-robin sharing of the clearing PRNG data port plus reseed sequencing.
// Periodic auto-reseed is enabled by defining AES_PRNG_CLR_AUTO_RESEED_EN.
module aes_prng_clearing_arb
    import aes_pkg::*;
#(
    parameter int unsigned NumReq       = 4,
    parameter int unsigned ReseedPeriod = PrngClrReseedPeriodDefault,
    parameter int unsigned IdxW         = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] ack_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    input  logic              reseed_req_i,
    output logic              reseed_ack_o,
    output logic              prng_data_req_o,
    input  logic              prng_data_ack_i,
    output logic              prng_reseed_req_o,
    input  logic              prng_reseed_ack_i,
    output logic              busy_o
);

    aes_prng_clr_arb_e r_state;
    aes_prng_clr_arb_e w_state_next;

    logic [IdxW-1:0] r_gnt;
    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_ptr_inc;
    logic            w_rr_valid;
    logic [IdxW-1:0] w_rr_idx;
    logic            w_auto_due;
    logic            w_reseed_go;
    logic            w_data_done;
    logic            w_reseed_done;

    aes_prng_clr_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_arb (
        .req_i   (req_i),
        .ptr_i   (r_ptr),
        .valid_o (w_rr_valid),
        .idx_o   (w_rr_idx)
    );

    assign w_data_done   = (r_state == CLR_DATA) && prng_data_ack_i;
    assign w_reseed_done = (r_state == CLR_RESEED) && prng_reseed_ack_i;
    assign w_reseed_go   = reseed_req_i || w_auto_due;
    assign w_ptr_inc     = (r_gnt == IdxW'(NumReq - 1)) ? '0 : r_gnt + IdxW'(1);

`ifdef AES_PRNG_CLR_AUTO_RESEED_EN
    localparam int unsigned CntW = $clog2(ReseedPeriod + 1);

    logic [CntW-1:0] r_word_cnt;

    // Counts acked data words since the last reseed; saturates at the period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word_cnt <= '0;
        end else if (w_reseed_done) begin
            r_word_cnt <= '0;
        end else if (w_data_done && (r_word_cnt != CntW'(ReseedPeriod))) begin
            r_word_cnt <= r_word_cnt + CntW'(1);
        end
    end

    assign w_auto_due = (r_word_cnt == CntW'(ReseedPeriod));
`else
    assign w_auto_due = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= CLR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; reseed wins over data and never interrupts a word.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLR_IDLE: begin
                if (w_reseed_go) begin
                    w_state_next = CLR_RESEED;
                end else if (w_rr_valid) begin
                    w_state_next = CLR_DATA;
                end
            end
            CLR_DATA: begin
                if (prng_data_ack_i) begin
                    w_state_next = CLR_IDLE;
                end
            end
            CLR_RESEED: begin
                if (prng_reseed_ack_i) begin
                    w_state_next = CLR_IDLE;
                end
            end
            default: w_state_next = CLR_IDLE;
        endcase
    end

    // Grant latches on the IDLE->DATA transition; pointer advances past each served consumer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else begin
            if ((r_state == CLR_IDLE) && !w_reseed_go && w_rr_valid) begin
                r_gnt <= w_rr_idx;
            end
            if (w_data_done) begin
                r_ptr <= w_ptr_inc;
            end
        end
    end

    // Output decode; acks pass straight through from the PRNG, qualified by state.
    always_comb begin
        ack_o             = '0;
        reseed_ack_o      = 1'b0;
        prng_data_req_o   = 1'b0;
        prng_reseed_req_o = 1'b0;
        busy_o            = 1'b0;
        case (r_state)
            CLR_DATA: begin
                prng_data_req_o = 1'b1;
                busy_o          = 1'b1;
                if (prng_data_ack_i) begin
                    ack_o[r_gnt] = 1'b1;
                end
            end
            CLR_RESEED: begin
                prng_reseed_req_o = 1'b1;
                busy_o            = 1'b1;
                reseed_ack_o      = prng_reseed_ack_i && reseed_req_i;
            end
            default: ;
        endcase
    end

    assign gnt_idx_o = r_gnt;

    a_params_ok: assert property (@(posedge clk_i)
        (ReseedPeriod >= 1) && (NumReq >= 2) && (NumReq <= 8));

    a_ack_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(ack_o));

    a_prng_req_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        !(prng_data_req_o && prng_reseed_req_o));

    // A consumer must hold its request until it is acked.
    a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == CLR_DATA) |-> req_i[r_gnt]);

endmodule
